// File: rtl/fft_pkg.sv
// fft_pkg: shared widths, Q1.15 constants and complex-sample type for the FFT core.
package fft_pkg;
  localparam int W = 16;
  localparam int Q_FRAC = 15;
  localparam logic signed [W-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [W-1:0] SAT_MIN = 16'sh8000;
  typedef struct packed {
    logic signed [W-1:0] re;
    logic signed [W-1:0] im;
  } cplx_t;
endpackage

// File: rtl/fft_round_sat.sv
// fft_round_sat: round half-up, arithmetic shift right by SH, saturate to W bits.
module fft_round_sat import fft_pkg::*; #(
  parameter int IW = 17,
  parameter int SH = 1
) (
  input  logic signed [IW-1:0] d_i,
  output logic signed [W-1:0]  q_o
);
  localparam logic [IW:0] RND = ({{IW{1'b0}}, 1'b1} << SH) >> 1;
  logic signed [IW:0] r, t;
  logic ovf;
  assign r = $signed({d_i[IW-1], d_i}) + $signed(RND);
  assign t = r >>> SH;
  // Out of range whenever the bits above the W-bit result are not a pure sign extension.
  assign ovf = t[IW:W-1] != {(IW-W+2){t[W-1]}};
  assign q_o = ovf ? (t[IW] ? SAT_MIN : SAT_MAX) : t[W-1:0];
endmodule

// File: rtl/fft_dif_butterfly_pipe.sv
// fft_dif_butterfly_pipe: 3-stage handshaked radix-2 DIF butterfly with optional conjugate twiddle.
module fft_dif_butterfly_pipe import fft_pkg::*; #(
  parameter int SCALE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                inv,
  input  logic signed [W-1:0] xr,
  input  logic signed [W-1:0] xi,
  input  logic signed [W-1:0] yr,
  input  logic signed [W-1:0] yi,
  input  logic signed [W-1:0] wr,
  input  logic signed [W-1:0] wi,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] ar,
  output logic signed [W-1:0] ai,
  output logic signed [W-1:0] br,
  output logic signed [W-1:0] bi
);
  localparam int PW = 2*W+1;
  logic en, v1_q, v2_q, v3_q, inv1_q, inv2_q;
  logic signed [W:0] sr_q, si_q, dr_q, di_q, s2r_q, s2i_q;
  cplx_t w_q;
  logic signed [PW-1:0] prr_q, pii_q, pir_q, pri_q;
  logic signed [PW:0] br_sum, bi_sum;
  logic signed [W-1:0] ar_d, ai_d, br_d, bi_d, ar_q, ai_q, br_q, bi_q;
  assign en = !(v3_q && !out_ready);
  assign in_ready = en;
  assign out_valid = v3_q;
  assign {ar, ai, br, bi} = {ar_q, ai_q, br_q, bi_q};
  // Conjugating the twiddle only flips the sign of the wi cross terms.
  assign br_sum = inv2_q ? (PW+1)'(prr_q) + (PW+1)'(pii_q) : (PW+1)'(prr_q) - (PW+1)'(pii_q);
  assign bi_sum = inv2_q ? (PW+1)'(pir_q) - (PW+1)'(pri_q) : (PW+1)'(pir_q) + (PW+1)'(pri_q);
  fft_round_sat #(.IW(W+1), .SH(SCALE)) u_ar (.d_i(s2r_q), .q_o(ar_d));
  fft_round_sat #(.IW(W+1), .SH(SCALE)) u_ai (.d_i(s2i_q), .q_o(ai_d));
  fft_round_sat #(.IW(PW+1), .SH(Q_FRAC+SCALE)) u_br (.d_i(br_sum), .q_o(br_d));
  fft_round_sat #(.IW(PW+1), .SH(Q_FRAC+SCALE)) u_bi (.d_i(bi_sum), .q_o(bi_d));
  always_ff @(posedge clk)
    if (!rst_n) begin
      {v1_q, v2_q, v3_q, inv1_q, inv2_q} <= '0;
      {sr_q, si_q, dr_q, di_q, s2r_q, s2i_q} <= '0;
      w_q <= '0;
      {prr_q, pii_q, pir_q, pri_q} <= '0;
      {ar_q, ai_q, br_q, bi_q} <= '0;
    end else if (en) begin
      v1_q <= in_valid;
      inv1_q <= inv;
      sr_q <= (W+1)'(xr) + (W+1)'(yr);
      si_q <= (W+1)'(xi) + (W+1)'(yi);
      dr_q <= (W+1)'(xr) - (W+1)'(yr);
      di_q <= (W+1)'(xi) - (W+1)'(yi);
      w_q <= '{re: wr, im: wi};
      v2_q <= v1_q;
      inv2_q <= inv1_q;
      s2r_q <= sr_q;
      s2i_q <= si_q;
      prr_q <= PW'(dr_q) * PW'($signed(w_q.re));
      pii_q <= PW'(di_q) * PW'($signed(w_q.im));
      pir_q <= PW'(di_q) * PW'($signed(w_q.re));
      pri_q <= PW'(dr_q) * PW'($signed(w_q.im));
      v3_q <= v2_q;
      ar_q <= ar_d;
      ai_q <= ai_d;
      br_q <= br_d;
      bi_q <= bi_d;
    end
endmodule

// File: tb/tb_fft_dif_butterfly_pipe.sv
// tb_fft_dif_butterfly_pipe: scoreboard bench for the pipelined DIF butterfly (SCALE=1 and SCALE=0).
module tb_fft_dif_butterfly_pipe;
  logic clk = 0, rst_n = 0, in_valid = 0, inv = 0, out_ready = 1, in_valid0 = 0;
  logic signed [15:0] xr = 0, xi = 0, yr = 0, yi = 0, wr = 0, wi = 0;
  logic in_ready, out_valid, in_ready0, out_valid0;
  logic signed [15:0] ar, ai, br, bi, ar0, ai0, br0, bi0;
  logic [63:0] sb[$];
  int checks = 0, failures = 0;

  fft_dif_butterfly_pipe #(.SCALE(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .inv(inv),
    .xr(xr), .xi(xi), .yr(yr), .yi(yi), .wr(wr), .wi(wi),
    .out_valid(out_valid), .out_ready(out_ready), .ar(ar), .ai(ai), .br(br), .bi(bi));

  fft_dif_butterfly_pipe #(.SCALE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0), .inv(inv),
    .xr(xr), .xi(xi), .yr(yr), .yi(yi), .wr(wr), .wi(wi),
    .out_valid(out_valid0), .out_ready(1'b1), .ar(ar0), .ai(ai0), .br(br0), .bi(bi0));

  always #5 clk = ~clk;

  function automatic logic [15:0] sat16(input longint v);
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return v[15:0];
  endfunction

  function automatic logic [63:0] model(input int sc, input logic signed [15:0] xr_, xi_, yr_, yi_,
                                        wr_, wi_, input logic iv);
    longint sr, si, dr, di, pr, pi;
    sr = longint'(xr_) + longint'(yr_);
    si = longint'(xi_) + longint'(yi_);
    dr = longint'(xr_) - longint'(yr_);
    di = longint'(xi_) - longint'(yi_);
    if (iv) begin
      pr = dr * longint'(wr_) + di * longint'(wi_);
      pi = di * longint'(wr_) - dr * longint'(wi_);
    end else begin
      pr = dr * longint'(wr_) - di * longint'(wi_);
      pi = di * longint'(wr_) + dr * longint'(wi_);
    end
    return {sat16((sr + (sc != 0 ? 1 : 0)) >>> sc), sat16((si + (sc != 0 ? 1 : 0)) >>> sc),
            sat16((pr + (longint'(1) << (14 + sc))) >>> (15 + sc)),
            sat16((pi + (longint'(1) << (14 + sc))) >>> (15 + sc))};
  endfunction

  // Inputs change just after posedge; both transfers are judged here at the preceding negedge.
  always @(negedge clk) begin
    logic [63:0] exp_v;
    if (rst_n) begin
      if (in_valid && in_ready) sb.push_back(model(1, xr, xi, yr, yi, wr, wi, inv));
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected got=%h expected=none", {ar, ai, br, bi});
        end else begin
          exp_v = sb.pop_front();
          if ({ar, ai, br, bi} !== exp_v) begin
            failures++;
            $display("FAIL sb_data got=%h expected=%h", {ar, ai, br, bi}, exp_v);
          end
        end
      end
    end
  end

  task automatic set_ops(input logic [15:0] a, b, c, d, e, f, input logic iv);
    xr = a; xi = b; yr = c; yi = d; wr = e; wi = f; inv = iv;
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 0 || in_ready !== 1 || {ar, ai, br, bi} !== 64'h0) begin
      failures++;
      $display("FAIL reset_state got v=%b rdy=%b out=%h expected v=0 rdy=1 out=0", out_valid, in_ready,
               {ar, ai, br, bi});
    end
    rst_n = 1;
  endtask

  task automatic test_basic;
    set_ops(16'h4000, 0, 16'h2000, 0, 16'h7FFF, 0, 0);
    @(posedge clk); #1 in_valid = 1;
    @(posedge clk); #1 in_valid = 0;
    checks++;
    if (out_valid !== 0) begin failures++; $display("FAIL basic_lat1 got=%b expected=0", out_valid); end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 0) begin failures++; $display("FAIL basic_lat2 got=%b expected=0", out_valid); end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1 || {ar, ai, br, bi} !== 64'h3000_0000_1000_0000) begin
      failures++;
      $display("FAIL basic_result got v=%b %h expected v=1 3000000010000000", out_valid, {ar, ai, br, bi});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_twiddle;
    set_ops(0, 0, 16'h4000, 0, 0, 16'h8000, 0);
    @(posedge clk); #1 in_valid = 1;
    @(posedge clk); #1 inv = 1;
    @(posedge clk); #1 in_valid = 0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1 || {ar, ai, br, bi} !== 64'h2000_0000_0000_2000) begin
      failures++;
      $display("FAIL twiddle_fwd got v=%b %h expected v=1 2000000000002000", out_valid, {ar, ai, br, bi});
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1 || {ar, ai, br, bi} !== 64'h2000_0000_0000_E000) begin
      failures++;
      $display("FAIL twiddle_inv got v=%b %h expected v=1 200000000000e000", out_valid, {ar, ai, br, bi});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation;
    set_ops(16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 0, 0);
    @(posedge clk); #1 in_valid0 = 1;
    @(posedge clk); #1 in_valid0 = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid0 !== 1 || {ar0, ai0, br0, bi0} !== 64'h7FFF_8000_0000_0000) begin
      failures++;
      $display("FAIL sat_scale0 got v=%b %h expected v=1 7fff800000000000", out_valid0,
               {ar0, ai0, br0, bi0});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [15:0] ops[6][6];
    logic [63:0] held;
    bit acc, emit;
    int idx = 0, outs = 0, stall = 0, cyc = 0;
    for (int k = 0; k < 6; k++) for (int j = 0; j < 6; j++) ops[k][j] = 16'($urandom);
    set_ops(ops[0][0], ops[0][1], ops[0][2], ops[0][3], ops[0][4], ops[0][5], 0);
    in_valid = 1;
    while ((idx < 6 || outs < 6) && cyc < 60) begin
      @(negedge clk);
      cyc++;
      acc = in_valid && in_ready;
      emit = out_valid && out_ready;
      if (stall > 0) begin
        checks++;
        if (in_ready !== 0) begin failures++; $display("FAIL stall_ready got=%b expected=0", in_ready); end
        if (stall == 4) held = {ar, ai, br, bi};
        else begin
          checks++;
          if (out_valid !== 1 || {ar, ai, br, bi} !== held) begin
            failures++;
            $display("FAIL stall_hold got v=%b %h expected v=1 %h", out_valid, {ar, ai, br, bi}, held);
          end
        end
      end
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 6) set_ops(ops[idx][0], ops[idx][1], ops[idx][2], ops[idx][3], ops[idx][4], ops[idx][5],
                             idx[0]);
        else in_valid = 0;
      end
      if (emit) begin
        outs++;
        if (outs == 2) begin out_ready = 0; stall = 4; end
      end else if (stall > 0) begin
        stall--;
        if (stall == 0) out_ready = 1;
      end
    end
    checks++;
    if (idx != 6 || outs != 6 || sb.size() != 0) begin
      failures++;
      $display("FAIL b2b_count got in=%0d out=%0d pending=%0d expected 6 6 0", idx, outs, sb.size());
    end
  endtask

  task automatic test_reset_midop;
    bit seen = 0;
    out_ready = 1;
    set_ops(16'h1234, 16'h0F00, 16'hF111, 16'h2222, 16'h5A82, 16'hA57E, 0);
    @(posedge clk); #1 in_valid = 1;
    repeat (3) @(posedge clk);
    #1 in_valid = 0;
    rst_n = 0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 0 || in_ready !== 1 || {ar, ai, br, bi} !== 64'h0) begin
      failures++;
      $display("FAIL midop_reset got v=%b rdy=%b out=%h expected v=0 rdy=1 out=0", out_valid, in_ready,
               {ar, ai, br, bi});
    end
    sb.delete();
    rst_n = 1;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    checks++;
    if (seen) begin failures++; $display("FAIL midop_stale got=1 expected=0"); end
  endtask

  task automatic test_random;
    int acc_n = 0, cyc = 0, dr_c = 0;
    logic [15:0] v[6];
    while (acc_n < 10000 && cyc < 60000) begin
      @(posedge clk); #1;
      for (int j = 0; j < 6; j++)
        v[j] = ($urandom_range(0, 7) == 0) ? ($urandom_range(0, 1) ? 16'h7FFF : 16'h8000) : 16'($urandom);
      set_ops(v[0], v[1], v[2], v[3], v[4], v[5], 1'($urandom_range(0, 1)));
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      cyc++;
      if (in_valid && in_ready) acc_n++;
    end
    @(posedge clk); #1;
    in_valid = 0;
    out_ready = 1;
    while (sb.size() != 0 && dr_c < 20) begin
      @(posedge clk); #1;
      dr_c++;
    end
    checks++;
    if (acc_n != 10000 || sb.size() != 0) begin
      failures++;
      $display("FAIL random_drain got acc=%0d pending=%0d expected 10000 0", acc_n, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_twiddle();
    test_saturation();
    test_back_to_back();
    test_reset_midop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fft_dif_butterfly_pipe.md
Name: fft_dif_butterfly_pipe

Overview:
- Pipelined, handshaked radix-2 decimation-in-frequency (DIF) butterfly for the 16-bit FFT/IFFT core.
- It is the inverse-direction counterpart of the combinational DIT butterfly_unit: twiddle is applied after the add/subtract, and an optional conjugate twiddle gives IFFT operation.
- Sits between the stage memory read port and the write-back path; one butterfly is accepted per cycle when not stalled.

Parameters:
- W, 16, data and twiddle width, signed Q1.15.
- SCALE, 1, 1 = divide both outputs by 2 (per-stage scaling); 0 = no scaling.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  operand set valid
- in_ready  output  1  block can accept operands this cycle
- inv  input  1  1 = use conjugate twiddle (IFFT); sampled with operands
- xr, xi, yr, yi  input  W each  complex operands x, y
- wr, wi  input  W each  twiddle W
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- ar, ai, br, bi  output  W each  results a, b

Behaviour:
- Arithmetic:
  - s = x + y and d = x − y, computed at W+1 bits.
  - Forward (inv=0): br = dr·wr − di·wi; bi = di·wr + dr·wi.
  - Inverse (inv=1): br = dr·wr + di·wi; bi = di·wr − dr·wi.
  - The 2W+1 bit products are summed at 2W+2 bits.
- Rounding:
  - a = (s + 2^(SCALE−1)) >>> SCALE; no rounding term when SCALE=0.
  - b = (sum + 2^(14+SCALE)) >>> (15+SCALE).
  - Round half-up, arithmetic shift.
- Saturation: every result is clamped to [0x8000, 0x7FFF]. Wrap-around is never permitted.
- Pipeline, 3 register stages:
  - S1 registers s, d, w, inv.
  - S2 registers the four products plus s.
  - S3 registers the rounded/saturated outputs.
  - Each stage has its own valid bit.
- Latency: 3 cycles from an accepted input to out_valid, in the absence of stall.
- Handshake:
  - en = !(out_valid && !out_ready); in_ready = en (combinational).
  - Transfer in occurs when in_valid && in_ready; transfer out when out_valid && out_ready.
  - When en=1, all stages advance; stage valid bits shift; a bubble is inserted when in_valid=0.
  - When en=0, all stage registers and valid bits hold.
  - While out_valid && !out_ready, ar/ai/br/bi are stable.
  - Bubbles are not compressed (simple global stall).
- Simultaneous accept/emit in the same cycle: both occur, giving full throughput of 1 per cycle.
- inv may change every transfer; it travels with its data.
- Reset (rst_n=0 at a clock edge, including mid-operation):
  - All valid bits are 0; out_valid=0.
  - ar=ai=br=bi=0.
  - In-flight data is discarded.
  - in_ready=1 from the cycle after reset, since out_valid=0.
- No X propagation: datapath registers are reset to 0.

Decomposition:
- Shared package fft_pkg: W, Q-format constants (Q_FRAC=15), SAT_MAX=16'sh7FFF, SAT_MIN=16'sh8000, and a complex-sample typedef {re, im}.
- One natural sub-module: fft_round_sat. It is parameterised by input width and shift, and performs round half-up, arithmetic shift, and saturation to W. It is instantiated four times.

Test Plan:
- Basic (SCALE=1, inv=0): x=(0x4000,0), y=(0x2000,0), W=(0x7FFF,0). Required result exactly 3 cycles after accept: a=(0x3000,0), b=(0x1000,0).
- Twiddle −j: x=(0,0), y=(0x4000,0), W=(0,0x8000). With inv=0: b=(0x0000,0x2000), a=(0x2000,0). With inv=1: b=(0x0000,0xE000).
- Saturation (SCALE=0): x=y=(0x7FFF,0x8000), W=(0x7FFF,0). Required: a=(0x7FFF,0x8000), b=(0,0).
- Back-to-back plus backpressure:
  - Stream 6 operand sets with in_valid=1 continuously; hold out_ready=0 from the 3rd output for 4 cycles.
  - Required: in_ready=0 during the stall; outputs stable during the stall; all 6 results appear in order, none lost or duplicated.
- Reset mid-operation: with 3 items in flight, drive rst_n=0 for one edge. Required: out_valid=0 and outputs 0 next cycle; no stale results emerge afterwards.
- Random regression: 10k random operands, inv, and ready toggling, checked against a bit-accurate reference model (same rounding and saturation).
